pipe_stage_skid: RTL
====================

// Module: pipe_stage_skid
// PURPOSE
//  Parametrised pipeline-boundary register; successor to the fixed-field stage registers (e.g. MEM/WB).
//  Carries a control vector and a data payload with a valid bit, ready/valid backpressure,
//  flush, and an optional 2-entry skid buffer so in_ready is registered (breaks ready timing path).
//  Instantiated between any two pipeline stages; payload layout is defined by the instantiating stage.
// PARAMETERS
//  DATA_W  32  payload width (ALU result, read data, dest register, ... concatenated by user)
//  CTRL_W  2   control-bit width (MemtoReg, RegWrite, ...); zeroed whenever out_valid=0
//  SKID    1   1: 2-entry skid buffer, registered in_ready; 0: single register, in_ready combinational
// PORTS
//  clk        in   1       clock, all state on rising edge
//  reset      in   1       synchronous, active-high; priority over every other input
//  flush      in   1       discard all held entries (branch/exception squash)
//  in_valid   in   1       upstream entry present
//  in_ready   out  1       stage can accept an entry this cycle
//  in_ctrl    in   CTRL_W  upstream control bits
//  in_data    in   DATA_W  upstream payload
//  out_valid  out  1       entry presented downstream
//  out_ready  in   1       downstream accepts (0 = stall)
//  out_ctrl   out  CTRL_W  held control bits; forced 0 when out_valid=0 (bubble = no side effects)
//  out_data   out  DATA_W  held payload
//  occupancy  out  2       entries held: 0,1,2 (2 only when SKID=1)
// BEHAVIOUR
//  Accept = in_valid & in_ready; Drain = out_valid & out_ready; evaluated at rising clk.
//  Reset (reset=1 at edge): main/skid valid=0, out_data=0, out_ctrl=0, occupancy=0; in_ready=1 next cycle.
//  Flush (reset=0, flush=1): both entries invalidated, occupancy=0; an Accept in the same cycle is
//   dropped (upstream is squashed too); in_ready is unaffected during the flush cycle itself.
//  Latency: entry accepted at edge N is on out_* after edge N (1 cycle) when stage was empty.
//  Stall: while out_valid=1 & out_ready=0, out_data/out_ctrl/out_valid hold stable (no change).
//  Order strictly FIFO; no entry duplicated or lost except by reset/flush.
//  SKID=1 state machine (state == occupancy):
//   EMPTY: Accept -> ONE (main <= in).
//   ONE:   Accept&Drain -> ONE (main <= in); Accept only -> TWO (skid <= in); Drain only -> EMPTY.
//   TWO:   in_ready=0; Drain -> ONE (main <= skid); else hold.
//   in_ready = (state != TWO), driven from a register (no comb path from out_ready).
//  SKID=0: single entry; in_ready = ~main_valid | out_ready (comb); Accept loads main;
//   Drain without Accept clears valid. occupancy in {0,1}.
//  Data registers need no reset beyond out_data/out_ctrl zero; invalid skid contents are don't-care
//   but must never reach out_* .
//  Width rule: payload copied bit-exact, no sign/zero extension; CTRL_W,DATA_W >= 1.
// TESTING
//  1 Reset: assert reset 2 cycles with in_valid=1 -> out_valid=0,out_ctrl=0,out_data=0,occupancy=0,in_ready=1.
//  2 Streaming SKID=1, out_ready=1: push data 0x11,0x22,0x33 back-to-back -> appear on consecutive
//    cycles, 1-cycle latency, occupancy stays 1, in_ready stays 1.
//  3 Stall: push 0xA0,0xA1,0xA2 with out_ready=0 -> 0xA0 held, occupancy=2, in_ready=0 after 2nd
//    accept, 0xA2 not accepted; release out_ready -> 0xA0,0xA1,0xA2 out in order, none lost.
//  4 Flush with occupancy=2 and in_valid=1 (data 0x55) -> next cycle out_valid=0,out_ctrl=0,
//    occupancy=0; 0x55 never appears on out_data with out_valid=1.
//  5 Bubble gating: in_ctrl=2'b11 with in_valid=0 -> out_ctrl stays 2'b00.
//  6 SKID=0 instance, DATA_W=8: out_ready toggled 1/0 each cycle with continuous input 0..9
//    -> in_ready tracks ~out_valid|out_ready same cycle; output sequence 0..9 in order.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Pipeline-boundary register with valid/ready backpressure, flush, and an optional
// 2-entry skid buffer that lets in_ready come straight from a flop.
module pipe_stage_skid #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 2,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);
  localparam bit USE_SKID = (SKID != 0);

  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
  logic              in_ready_q,   in_ready_d;
  logic              accept, drain;

  assign in_ready  = USE_SKID ? in_ready_q : (~main_valid_q | out_ready);
  assign accept    = in_valid & in_ready;
  assign drain     = main_valid_q & out_ready;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  // A bubble must never carry control bits downstream.
  assign out_ctrl  = main_valid_q ? main_ctrl_q : {CTRL_W{1'b0}};
  assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_ctrl_d  = main_ctrl_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_ctrl_d  = skid_ctrl_q;
    in_ready_d   = in_ready_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      in_ready_d   = 1'b1;
    end else if (USE_SKID) begin
      case ({main_valid_q, skid_valid_q})
        2'b00: if (accept) begin
          main_valid_d = 1'b1;
          main_data_d  = in_data;
          main_ctrl_d  = in_ctrl;
        end
        2'b10: begin
          if (accept && drain) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
            skid_ctrl_d  = in_ctrl;
          end else if (drain) begin
            main_valid_d = 1'b0;
          end
        end
        2'b11: if (drain) begin
          main_data_d  = skid_data_q;
          main_ctrl_d  = skid_ctrl_q;
          skid_valid_d = 1'b0;
        end
        default: ;
      endcase
      // Registered ready: computed from next occupancy, never from out_ready directly.
      in_ready_d = ~(main_valid_d & skid_valid_d);
    end else begin
      if (accept) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
        main_ctrl_d  = in_ctrl;
      end else if (drain) begin
        main_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_ctrl_q  <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_ctrl_q  <= main_ctrl_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  // Skid contents are only meaningful while skid_valid_q is set.
  always_ff @(posedge clk) begin
    skid_data_q <= skid_data_d;
    skid_ctrl_q <= skid_ctrl_d;
  end
endmodule
